serial_sub: RTL and testbench

- Bit-serial subtractor: computes A - B - bi one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- Minimum-gate counterpart to the parallel ripple adder, for the ALU subtract path where area matters more than latency.
- start/busy/done handshake to the sequencer. Result and flags are held until the next accepted start.

---
 rtl/serial_sub_if.sv | 49 ++++
 rtl/serial_sub.sv | 147 ++++++++++++++
 tb/tb_serial_sub.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/serial_sub_if.sv
// rtl/serial_sub_if.sv - start/busy/done handshake and operand/result bundle for serial_sub
//
// Purpose : groups the sequencer-facing signals of the bit-serial subtractor.
// Signals : start    request, sampled on a rising clk edge
//           bi       borrow in, latched with the operands
//           A, B     minuend / subtrahend (WIDTH bits)
//           out      difference (A - B - bi) mod 2^WIDTH
//           bo       borrow out (A < B + bi, unsigned)
//           zero     out == 0
//           busy     serial operation in progress
//           done     one-cycle pulse when out/bo/zero become valid
//           ovf      signed overflow, only when SERIAL_SUB_OVF_EN is defined
// Modports: master = sequencer side, slave = subtractor side.
interface serial_sub_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             bi;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] out;
    logic             bo;
    logic             zero;
    logic             busy;
    logic             done;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (
        output start, bi, A, B,
        input  out, bo, zero, busy, done, ovf
    );

    modport slave (
        input  start, bi, A, B,
        output out, bo, zero, busy, done, ovf
    );
`else
    modport master (
        output start, bi, A, B,
        input  out, bo, zero, busy, done
    );

    modport slave (
        input  start, bi, A, B,
        output out, bo, zero, busy, done
    );
`endif
endinterface

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial subtractor, one full-subtractor cell plus borrow flop
//
// Purpose : computes A - B - bi one bit per clock, LSB first. Result and flags
//           are held until the next accepted start.
// Ports   : clk    single clock, rising edge
//           rst_n  asynchronous active-low reset
//           bus    serial_sub_if.slave (start, bi, A, B, out, bo, zero, busy, done[, ovf])
// Option  : SERIAL_SUB_OVF_EN adds the ovf output (two's-complement overflow).
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_sub_if.slave  bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_sha;
    logic [WIDTH-1:0] r_shb;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] r_out;
    logic             r_bo;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic             w_a;
    logic             w_b;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;
    logic             w_busy;
    logic             w_done;

    // A start is only honoured outside RUN; DONE accepts it for back-to-back ops.
    assign w_accept = bus.start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);

    // Full-subtractor cell
    assign w_a        = r_sha[0];
    assign w_b        = r_shb[0];
    assign w_d        = w_a ^ w_b ^ r_br;
    assign w_br_next  = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = bus.start ? S_RUN : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sha  <= '0;
            r_shb  <= '0;
            r_res  <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_out  <= '0;
            r_bo   <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_sha <= bus.A;
            r_shb <= bus.B;
            r_br  <= bus.bi;
            r_res <= '0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_sha <= r_sha >> 1;
            r_shb <= r_shb >> 1;
            r_br  <= w_br_next;
            r_res <= w_res_next;
            r_cnt <= r_cnt + CW'(1);
            // Visible result only changes on the final bit, so out/bo/zero
            // keep the previous answer throughout RUN.
            if (w_last) begin
                r_out  <= w_res_next;
                r_bo   <= w_br_next;
                r_zero <= (w_res_next == '0);
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;

    // On the last bit r_br is the borrow into the MSB and w_br_next the borrow out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last && !w_accept) begin
            r_ovf <= r_br ^ w_br_next;
        end
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.out  = r_out;
    assign bus.bo   = r_bo;
    assign bus.zero = r_zero;
    assign bus.busy = w_busy;
    assign bus.done = w_done;

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - randomized and directed self-checking bench for serial_sub
module tb_serial_sub;

    localparam int W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    serial_sub_if #(.WIDTH(W)) bus();

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Currently held (visible) result and the result of the op in flight
    logic [W-1:0] m_out;
    logic         m_bo, m_zero, m_ovf;
    logic [W-1:0] p_out;
    logic         p_bo, p_zero, p_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output logic [W-1:0] o, output logic brw, output logic z,
                         output logic ov);
        int d, sa, sb, sd;
        d   = int'(a) - int'(b) - int'(c);
        o   = d[W-1:0];
        brw = (d < 0);
        z   = (o == '0);
        sa  = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb  = b[W-1] ? int'(b) - (1 << W) : int'(b);
        sd  = sa - sb - int'(c);
        ov  = (sd > (1 << (W-1)) - 1) || (sd < -(1 << (W-1)));
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.bi    = c;
        model(a, b, c, p_out, p_bo, p_zero, p_ovf);
    endtask

    // Called at the negedge where start is driven; returns at the done negedge.
    // inject=1 pulses start with new operands while the op is running.
    task automatic finish_op(input bit inject);
        int cyc;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 3 * W) begin
            check("busy_run", 32'(bus.busy), 32'd1);
            check("hold_out", 32'(bus.out), 32'(m_out));
            check("hold_bo", 32'(bus.bo), 32'(m_bo));
            if (inject && cyc == 1) begin
                bus.start = 1'b1;
                bus.A     = 1;
                bus.B     = 1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(W));
        check("out", 32'(bus.out), 32'(p_out));
        check("bo", 32'(bus.bo), 32'(p_bo));
        check("zero", 32'(bus.zero), 32'(p_zero));
        check("busy_done", 32'(bus.busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", 32'(bus.ovf), 32'(p_ovf));
`endif
        m_out  = p_out;
        m_bo   = p_bo;
        m_zero = p_zero;
        m_ovf  = p_ovf;
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(negedge clk);
        start_op(a, b, c);
        finish_op(1'b0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.bi    = 1'b0;
        m_out = '0; m_bo = 1'b0; m_zero = 1'b0; m_ovf = 1'b0;

        @(negedge clk);
        check("rst_out", 32'(bus.out), 32'd0);
        check("rst_bo", 32'(bus.bo), 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;

        // Directed cases
        op(4'd9, 4'd3, 1'b0);
        op(4'd3, 4'd9, 1'b0);
        op(4'd5, 4'd5, 1'b1);
        op(4'd0, 4'd0, 1'b0);
        // Back-to-back: start held in the DONE cycle
        start_op(4'd7, 4'd2, 1'b0);
        finish_op(1'b0);

        // Start while busy is ignored, single done pulse
        @(negedge clk);
        start_op(4'd9, 4'd3, 1'b0);
        finish_op(1'b1);
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check("single_done", 32'(bus.done), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
        end

        // Reset mid-operation
        start_op(4'd9, 4'd3, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out", 32'(bus.out), 32'd0);
        check("abort_bo", 32'(bus.bo), 32'd0);
        check("abort_zero", 32'(bus.zero), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        #3;
        rst_n = 1'b1;
        m_out = '0; m_bo = 1'b0; m_zero = 1'b0; m_ovf = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check("no_done_after_abort", 32'(bus.done), 32'd0);
        end
        op(4'hF, 4'h1, 1'b0);

        // Signed overflow cases
        op(4'd8, 4'd1, 1'b0);
        op(4'd7, 4'hF, 1'b0);
        op(4'd6, 4'd2, 1'b0);

        // Randomized, mixing idle gaps and back-to-back starts
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                @(negedge clk);
            end
            start_op(ra, rb, rc);
            finish_op(1'b0);
        end

        @(negedge clk);
        check("final_done", 32'(bus.done), 32'd0);
        check("final_out", 32'(bus.out), 32'(m_out));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
